// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder reused over WIDTH cycles, LSB first.
// Define SERIAL_ADDER_SUB_EN to enable two's-complement subtraction via `sub`.
`timescale 1ns/1ps

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa, sb, sr;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_cout;
  logic             last;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Subtraction is a + ~b + 1, so it only changes what gets loaded at start.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~op_b : op_b;
  assign c_load = sub ? 1'b1  : cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_load     = op_b;
  assign c_load     = cin;
`endif

  full_adder u_fa (
    .a   (sa[0]),
    .b   (sb[0]),
    .cin (c),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  assign last = (state_q == RUN) && (cnt == CW'(WIDTH - 1));
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          sa  <= op_a;
          sb  <= b_load;
          c   <= c_load;
          cnt <= '0;
        end
        RUN: begin
          sr  <= {fa_sum, sr[WIDTH-1:1]};
          c   <= fa_cout;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + CW'(1);
          // Final bit lands straight into result; sr itself is one step behind here.
          if (last) begin
            result <= {fa_sum, sr[WIDTH-1:1]};
            cout   <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): vector table plus corner sequences.
`timescale 1ns/1ps

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic         cin = 1'b0, sub = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_a(op_a), .op_b(op_b),
    .cin(cin), .sub(sub), .busy(busy), .done(done), .result(result), .cout(cout)
  );

  typedef struct {
    logic [7:0] a, b;
    logic       ci, sb;
    logic [7:0] exp_r;
    logic       exp_c;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Issue one start, then watch until done. k counts negedges after the accept edge.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic sb, output logic [7:0] r, output logic co,
                       output int lat, output int bcnt, output int held);
    logic [7:0] prev;
    logic       got;
    @(negedge clk);
    op_a = a; op_b = b; cin = ci; sub = sb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    op_a = 8'($urandom); op_b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    prev = result; got = 1'b0; lat = 0; bcnt = 0; held = 1; r = '0; co = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        got = 1'b1; lat = k; r = result; co = cout;
      end else if (result !== prev) held = 0;
    end
    @(negedge clk);
    if (busy) bcnt++;
    if (done) held = 0;
  endtask

  vec_t vt[8];
  logic [7:0] r;
  logic co;
  int lat, bcnt, held, ndone, idx[$];

  initial begin
    vt[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
    vt[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
    vt[4] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0};
`ifdef SERIAL_ADDER_SUB_EN
    vt[5] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1};
    vt[6] = '{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0};
    vt[7] = '{8'hA5, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b1};
`else
    vt[5] = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h11, 1'b0};
    vt[6] = '{8'h01, 8'h02, 1'b0, 1'b1, 8'h03, 1'b0};
    vt[7] = '{8'hA5, 8'hA5, 1'b1, 1'b1, 8'h4B, 1'b1};
`endif

    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_cout", 32'(cout), 0);
    @(negedge clk); reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(vt[i].a, vt[i].b, vt[i].ci, vt[i].sb, r, co, lat, bcnt, held);
      chk($sformatf("v%0d_result", i), 32'(r), 32'(vt[i].exp_r));
      chk($sformatf("v%0d_cout", i), 32'(co), 32'(vt[i].exp_c));
      chk($sformatf("v%0d_latency", i), 32'(lat), W + 1);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), W + 1);
      chk($sformatf("v%0d_result_held", i), 32'(held), 1);
    end

    // Start while busy: second request at cycle 3 must be dropped.
    @(negedge clk);
    op_a = 8'h01; op_b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0; r = '0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 3) begin op_a = 8'h7F; op_b = 8'h7F; start = 1'b1; end
      if (k == 4) start = 1'b0;
      @(negedge clk);
      if (done) begin ndone++; r = result; end
    end
    chk("busy_start_result", 32'(r), 32'h02);
    chk("busy_start_ndone", 32'(ndone), 1);
    chk("busy_start_idle", 32'(busy), 0);

    // Reset mid-operation.
    @(negedge clk);
    op_a = 8'h12; op_b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_result", 32'(result), 0);
    chk("midrst_cout", 32'(cout), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 0);
    do_op(8'h12, 8'h34, 1'b0, 1'b0, r, co, lat, bcnt, held);
    chk("after_rst_result", 32'(r), 32'h46);
    chk("after_rst_latency", 32'(lat), W + 1);

    // Back-to-back: start held high.
    @(negedge clk);
    op_a = 8'h10; op_b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
    idx.delete();
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done) begin
        idx.push_back(k);
        chk($sformatf("b2b_result%0d", idx.size()), 32'(result), 32'h30);
        chk($sformatf("b2b_cout%0d", idx.size()), 32'(cout), 0);
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(idx.size()), 4);
    if (idx.size() >= 2)
      for (int j = 1; j < idx.size(); j++)
        chk($sformatf("b2b_period%0d", j), 32'(idx[j] - idx[j-1]), W + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Sequencer that performs a WIDTH-bit addition by time-multiplexing one existing `full_adder` instance over WIDTH clock cycles, LSB first, with a registered carry between bit-steps. It sits between a requester (start/done handshake) and the single-bit adder datapath. It trades latency for area against the ripple-carry adder. An optional compile-time mode adds two's-complement subtraction on the same adder.

## Interface

Parameters:
- `WIDTH`, default 8: operand/result width in bits, minimum 2.

Ports:
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request pulse; sampled only in IDLE.
- `op_a`  input  WIDTH  operand A; captured on accepted start.
- `op_b`  input  WIDTH  operand B; captured on accepted start.
- `cin`  input  1  carry-in; captured on accepted start.
- `sub`  input  1  subtract request; captured on accepted start; functional only with the macro below.
- `busy`  output  1  high in RUN and DONE.
- `done`  output  1  one-cycle pulse when `result`/`cout` update.
- `result`  output  WIDTH  sum/difference; holds until the next completion.
- `cout`  output  1  final carry out of the MSB step.

## Operation

- Internal: one `full_adder` instance (`a`, `b`, `cin`, `sum`, `cout`), shift registers `sa`/`sb`/`sr` (WIDTH each), carry flop `c`, bit counter `cnt` (ceil(log2(WIDTH+1)) bits), 2-bit state.
- Adder inputs are wired as `a`=`sa[0]`, `b`=`sb[0]`, `cin`=`c`. No other logic drives the adder.
- IDLE:
  - `start`=1 → `sa`<=`op_a`, `sb`<=`op_b`, `c`<=`cin`, `cnt`<=0, go RUN.
  - `start`=0 → stay IDLE.
- RUN, each cycle:
  - `sr`<={adder `sum`, `sr[WIDTH-1:1]`}.
  - `c`<=adder `cout`.
  - `sa`, `sb` shift right by 1.
  - `cnt`<=`cnt`+1.
  - When `cnt`==WIDTH-1 (last bit step): go DONE and load `result`<=final shifted `sr` value and `cout`<=adder `cout`, both on that same edge.
- DONE: `done`=1 for exactly one cycle; next edge returns to IDLE unconditionally.
- `start` asserted in RUN or DONE is ignored and not queued.
- Operand inputs may change freely after the accepted start; only the captured copies are used.
- Arithmetic: `result` = (`op_a` + `op_b` + `cin`) mod 2^WIDTH; `cout` = bit WIDTH of that sum.
- Reset (asynchronous, any state, including mid-RUN):
  - State → IDLE.
  - `busy`, `done`, `cout` = 0; `result` = 0.
  - `sa`, `sb`, `sr`, `c`, `cnt` = 0.
  - The interrupted operation is discarded and no `done` is produced for it.

## Timing

- Start accepted at edge E0 (state IDLE, `start`=1). `busy` rises after E0.
- Bit i (i = 0..WIDTH-1) is computed during the cycle after edge E0+i and registered at edge E0+i+1.
- `result`, `cout` and `done` become valid after edge E0+WIDTH.
- `done` is high for the single cycle between E0+WIDTH and E0+WIDTH+1. `busy` falls after E0+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accepted start is at edge E0+WIDTH+2.
- `result`/`cout` do not change during RUN; the previous values remain visible until the completion edge.
- All outputs are registered; no combinational path exists from inputs to outputs.

## Configuration

- Macro: `SERIAL_ADDER_SUB_EN`.
- Defined:
  - On accepted start with `sub`=1: `sb`<=~`op_b` and `c`<=1. `cin` is ignored.
  - `result` = (`op_a` − `op_b`) mod 2^WIDTH.
  - `cout`=1 means no borrow (`op_a` ≥ `op_b`, unsigned).
  - With `sub`=0, behaviour is the plain add described above.
- Not defined: `sub` is ignored (port kept, left unconnected internally) and the block always adds.

## Test plan

All cases use WIDTH=8.

- Add, no carry: `op_a`=0x5A, `op_b`=0x3C, `cin`=0, one-cycle start → `done` exactly 8 edges after the start edge; `result`=0x96, `cout`=0; `busy` high for 9 cycles.
- Wrap-around / carry: 0xFF+0x01, `cin`=0 → `result`=0x00, `cout`=1. Then 0xFF+0xFF, `cin`=1 → `result`=0xFF, `cout`=1.
- Start while busy: start 0x01+0x01, then pulse `start` with 0x7F+0x7F at cycle 3 → the second request is ignored; `result`=0x02, exactly one `done` pulse; `busy` low after DONE.
- Reset mid-operation: start 0x12+0x34, assert `reset_n`=0 at cycle 4 for 2 cycles → all outputs 0 immediately; no `done` pulse. A new start of 0x12+0x34 afterwards completes with `result`=0x46.
- Back-to-back requests: hold `start` high continuously with 0x10+0x20 → completions every 10 cycles, each with `result`=0x30, `cout`=0.
- With `SERIAL_ADDER_SUB_EN`: `sub`=1, 0x10−0x01 → `result`=0x0F, `cout`=1. Then 0x01−0x02 → `result`=0xFF, `cout`=0. Without the macro, the same stimulus gives 0x11 and 0x03.
